// File: rtl/recovery_ctrl_if.sv
// Bus between the lockstep comparator/cores and recovery_ctrl.
// master: comparator/core side, slave: recovery controller.
interface recovery_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  enable_i;
    logic                  error_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] data_i;

    logic                  rf_we_o;
    logic [ADDR_WIDTH-1:0] rf_addr_o;
    logic [DATA_WIDTH-1:0] rf_data_o;
    logic                  halt_o;
    logic                  recover_o;
    logic [ADDR_WIDTH-1:0] rec_addr_o;
    logic                  fatal_o;
    logic [7:0]            err_count_o;

    modport master (
        output enable_i, error_i, we_i, addr_i, data_i,
        input  rf_we_o, rf_addr_o, rf_data_o, halt_o, recover_o,
               rec_addr_o, fatal_o, err_count_o
    );

    modport slave (
        input  enable_i, error_i, we_i, addr_i, data_i,
        output rf_we_o, rf_addr_o, rf_data_o, halt_o, recover_o,
               rec_addr_o, fatal_o, err_count_o
    );
endinterface

// File: rtl/recovery_ctrl.sv
// Lockstep recovery controller: commits agreed writes to the golden
// register file, and on a comparator mismatch stalls the cores, sweeps
// every register back from the golden file and resumes. Too many
// consecutive recoveries without a commit in between ends in FATAL.
//
// Optional feature: define FT_ERR_COUNTER_EN for a saturating 8-bit
// lifetime mismatch counter on err_count_o (tied to 0 otherwise).
//
// state   | meaning
// RUN     | normal operation, agreed writes are committed
// HALT    | cores stalled, pipeline draining (HALT_CYCLES cycles)
// RESTORE | cores reload registers 0..2^ADDR_WIDTH-1 from golden file
// RESUME  | one last stalled cycle, retry count bumped
// FATAL   | unrecoverable, absorbing until reset
module recovery_ctrl #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_RETRY   = 3,
    parameter int HALT_CYCLES = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    recovery_ctrl_if.slave bus
);

    // retry_cnt never exceeds MAX_RETRY-1: an error at that value goes FATAL
    localparam int RW        = (MAX_RETRY > 2) ? $clog2(MAX_RETRY) : 1;
    localparam int HW        = (HALT_CYCLES > 2) ? $clog2(HALT_CYCLES) : 1;
    localparam int HC_LOAD   = (HALT_CYCLES > 0) ? HALT_CYCLES - 1 : 0;
    localparam bit SKIP_HALT = (HALT_CYCLES == 0);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        HALT    = 3'd1,
        RESTORE = 3'd2,
        RESUME  = 3'd3,
        FATAL   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  accept_err;
    logic                  commit;
    logic                  halt;
    logic                  recover;
    logic                  fatal;
    logic [RW-1:0]         retry_cnt;
    logic [HW-1:0]         halt_cnt;
    logic [ADDR_WIDTH-1:0] rec_addr;
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_data;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, error acceptance/commit qualification and status outputs
    always_comb begin
        state_nxt  = state;
        accept_err = 1'b0;
        commit     = 1'b0;
        halt       = 1'b1;
        recover    = 1'b0;
        fatal      = 1'b0;
        case (state)
            RUN: begin
                halt = 1'b0;
                if (bus.enable_i && bus.error_i) begin
                    accept_err = 1'b1;
                    if (retry_cnt == RW'(MAX_RETRY - 1)) begin
                        state_nxt = FATAL;
                    end else if (SKIP_HALT) begin
                        state_nxt = RESTORE;
                    end else begin
                        state_nxt = HALT;
                    end
                end else if (bus.enable_i && bus.we_i) begin
                    commit = 1'b1;
                end
            end
            HALT: begin
                if (halt_cnt == '0) begin
                    state_nxt = RESTORE;
                end
            end
            RESTORE: begin
                recover = 1'b1;
                if (rec_addr == '1) begin
                    state_nxt = RESUME;
                end
            end
            RESUME: begin
                state_nxt = RUN;
            end
            FATAL: begin
                fatal = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Drain timer: loaded on entry to HALT, counts down to terminal count 0
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            halt_cnt <= '0;
        end else if (state != HALT && state_nxt == HALT) begin
            halt_cnt <= HW'(HC_LOAD);
        end else if (state == HALT && halt_cnt != '0) begin
            halt_cnt <= halt_cnt - 1'b1;
        end
    end

    // Restore sweep address: steps through every register, 0 outside RESTORE
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rec_addr <= '0;
        end else if (state == RESTORE) begin
            rec_addr <= rec_addr + 1'b1;
        end else begin
            rec_addr <= '0;
        end
    end

    // Consecutive recovery count: cleared by a commit, bumped on each RESUME
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            retry_cnt <= '0;
        end else if (commit) begin
            retry_cnt <= '0;
        end else if (state == RESUME) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end

    // Commit path to the golden file: one-cycle registered strobe, address and data
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= commit;
            if (commit) begin
                rf_addr <= bus.addr_i;
                rf_data <= bus.data_i;
            end
        end
    end

    assign bus.rf_we_o    = rf_we;
    assign bus.rf_addr_o  = rf_addr;
    assign bus.rf_data_o  = rf_data;
    assign bus.halt_o     = halt;
    assign bus.recover_o  = recover;
    assign bus.rec_addr_o = rec_addr;
    assign bus.fatal_o    = fatal;

`ifdef FT_ERR_COUNTER_EN
    logic [7:0] err_count;

    // Lifetime mismatch counter, saturating at 255
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_count <= 8'd0;
        end else if (accept_err && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

    assign bus.err_count_o = err_count;
`else
    assign bus.err_count_o = 8'd0;
`endif

endmodule
